// File: rtl/maze_collision_detector.sv
// Per-frame collision detector: samples the wall vector against the player box and four
// one-step probe strips. Optional 18-bit hit mask enabled by defining COLLIDE_HITMASK_EN.
module maze_collision_detector #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SIZE     = 16,
    parameter int STEP     = 4,
    parameter int WALL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  xCount,
    input  logic [9:0]  yCount,
    input  logic [17:0] wall,
    input  logic [9:0]  px,
    input  logic [9:0]  py,
    input  logic        res_ack,
    output logic        res_valid,
    output logic [3:0]  blocked,
    output logic        overlap,
    output logic        overrun,
    output logic [17:0] hit_mask
);
    localparam logic [10:0] SZ    = 11'(SIZE);
    localparam logic [10:0] ST    = 11'(STEP);
    localparam logic [10:0] H_END = 11'(H_ACTIVE);
    localparam logic [10:0] V_END = 11'(V_ACTIVE);

    typedef enum logic {WAIT_SOF = 1'b0, SCAN = 1'b1} state_t;

    state_t state_q, state_d;
    logic [WALL_LAT-1:0][9:0] xpipe_q, ypipe_q;
    logic [9:0]  yprev_q, pl_q, pt_q;
    logic [3:0]  blk_acc_q, blk_acc_d;
    logic        ovl_acc_q, ovl_acc_d;
    logic        res_valid_q, overlap_q, overrun_q;
    logic [3:0]  blocked_q;
    logic        publish;

    // Counts delayed to line up with the wall vector of the same pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            xpipe_q <= '0;
            ypipe_q <= '0;
            yprev_q <= '0;
        end else begin
            xpipe_q[0] <= xCount;
            ypipe_q[0] <= yCount;
            for (int i = 1; i < WALL_LAT; i++) begin
                xpipe_q[i] <= xpipe_q[i-1];
                ypipe_q[i] <= ypipe_q[i-1];
            end
            yprev_q <= ypipe_q[WALL_LAT-1];
        end
    end

    logic [10:0] x11, y11, yp11, l11, t11;
    logic        sof, eof, any_wall;
    assign x11  = {1'b0, xpipe_q[WALL_LAT-1]};
    assign y11  = {1'b0, ypipe_q[WALL_LAT-1]};
    assign yp11 = {1'b0, yprev_q};
    assign sof  = (y11 == 11'd0) && (yp11 != 11'd0);
    assign eof  = (y11 >= V_END) && (yp11 < V_END);
    assign any_wall = |wall;

    // The SOF pixel already belongs to the new frame, so compare it against the new position
    assign l11 = sof ? {1'b0, px} : {1'b0, pl_q};
    assign t11 = sof ? {1'b0, py} : {1'b0, pt_q};

    logic in_xb, in_yb, in_yu, in_yd, in_xl, in_xr;
    logic hit_body, hit_up, hit_dn, hit_lf, hit_rt;
    logic [3:0] strip_hit;
    logic       body_hit;
    assign in_xb = (x11 >= l11) && (x11 < l11 + SZ);
    assign in_yb = (y11 >= t11) && (y11 < t11 + SZ);
    assign in_yu = (y11 < t11) && (y11 + ST >= t11);
    assign in_yd = (y11 >= t11 + SZ) && (y11 < t11 + SZ + ST);
    assign in_xl = (x11 < l11) && (x11 + ST >= l11);
    assign in_xr = (x11 >= l11 + SZ) && (x11 < l11 + SZ + ST);
    assign hit_body  = in_xb && in_yb;
    assign hit_up    = in_xb && in_yu;
    assign hit_dn    = in_xb && in_yd;
    assign hit_lf    = in_yb && in_xl;
    assign hit_rt    = in_yb && in_xr;
    assign strip_hit = {hit_up, hit_dn, hit_lf, hit_rt} & {4{any_wall}};
    assign body_hit  = hit_body && any_wall;

    logic [3:0] clamp;
    assign clamp = {({1'b0, pt_q} < ST),
                    ({1'b0, pt_q} + SZ + ST > V_END),
                    ({1'b0, pl_q} < ST),
                    ({1'b0, pl_q} + SZ + ST > H_END)};

    always_ff @(posedge clk) begin
        if (sof) begin
            pl_q <= px;
            pt_q <= py;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_SOF;
            blk_acc_q <= '0;
            ovl_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_acc_q <= blk_acc_d;
            ovl_acc_q <= ovl_acc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        blk_acc_d = blk_acc_q;
        ovl_acc_d = ovl_acc_q;
        publish   = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                if (sof) begin
                    state_d   = SCAN;
                    blk_acc_d = strip_hit;
                    ovl_acc_d = body_hit;
                end
            end
            SCAN: begin
                if (sof) begin
                    blk_acc_d = strip_hit;
                    ovl_acc_d = body_hit;
                end else begin
                    blk_acc_d = blk_acc_q | strip_hit;
                    ovl_acc_d = ovl_acc_q | body_hit;
                    publish   = eof;
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    // Result registers and valid/ack handshake; a publish always wins over a pending ack
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            blocked_q   <= '0;
            overlap_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (publish) begin
            blocked_q   <= blk_acc_q | clamp;
            overlap_q   <= ovl_acc_q;
            res_valid_q <= 1'b1;
            if (res_valid_q && !res_ack) overrun_q <= 1'b1;
        end else if (res_valid_q && res_ack) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid = res_valid_q;
    assign blocked   = blocked_q;
    assign overlap   = overlap_q;
    assign overrun   = overrun_q;

`ifdef COLLIDE_HITMASK_EN
    logic [17:0] hm_acc_q, hm_acc_d, hm_q, region_wall;
    assign region_wall = (hit_body | hit_up | hit_dn | hit_lf | hit_rt) ? wall : '0;

    always_comb begin
        hm_acc_d = hm_acc_q;
        if (sof) hm_acc_d = region_wall;
        else if (state_q == SCAN) hm_acc_d = hm_acc_q | region_wall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hm_acc_q <= '0;
            hm_q     <= '0;
        end else begin
            hm_acc_q <= hm_acc_d;
            if (publish) hm_q <= hm_acc_q;
        end
    end

    assign hit_mask = hm_q;
`else
    assign hit_mask = '0;
`endif

endmodule

// File: tb/tb_maze_collision_detector.sv
// Directed bench for maze_collision_detector: compressed raster frames around the player,
// expected flags queued per frame from a rectangle-intersection model.
module tb_maze_collision_detector;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  xCount, yCount, px, py;
    logic [17:0] wall;
    logic        res_ack;
    logic        res_valid, overlap, overrun;
    logic [3:0]  blocked;
    logic [17:0] hit_mask;

    always #5 clk = ~clk;

    maze_collision_detector dut (
        .clk(clk), .rst(rst), .xCount(xCount), .yCount(yCount), .wall(wall),
        .px(px), .py(py), .res_ack(res_ack), .res_valid(res_valid),
        .blocked(blocked), .overlap(overlap), .overrun(overrun), .hit_mask(hit_mask)
    );

    typedef struct {
        logic [3:0]  blk;
        logic        ovl;
        logic [17:0] hm;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wx0, wx1, wy0, wy1, widx;
    bit   wall_en;

    function automatic logic [17:0] wall_at(int x, int y);
        if (wall_en && x >= wx0 && x <= wx1 && y >= wy0 && y <= wy1 && y < 480)
            return 18'(1) << widx;
        return '0;
    endfunction

    // Wall generator model: one cycle behind the counts
    always @(posedge clk) wall <= wall_at(int'(xCount), int'(yCount));

    function automatic bit ov(int a0, int a1, int b0, int b1);
        return (a0 <= b1) && (b0 <= a1);
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic exp_t model(int pl, int pt);
        exp_t e;
        bit b, u, d, l, r;
        b = wall_en && ov(wx0, wx1, pl, pl + 15) && ov(wy0, wy1, pt, pt + 15);
        u = wall_en && ov(wx0, wx1, pl, pl + 15) && ov(wy0, wy1, pt - 4, pt - 1);
        d = wall_en && ov(wx0, wx1, pl, pl + 15) && ov(wy0, wy1, pt + 16, pt + 19);
        l = wall_en && ov(wy0, wy1, pt, pt + 15) && ov(wx0, wx1, pl - 4, pl - 1);
        r = wall_en && ov(wy0, wy1, pt, pt + 15) && ov(wx0, wx1, pl + 16, pl + 19);
        e.blk = {u || (pt < 4), d || (pt + 20 > 480), l || (pl < 4), r || (pl + 20 > 640)};
        e.ovl = b;
`ifdef COLLIDE_HITMASK_EN
        e.hm = (b || u || d || l || r) ? (18'(1) << widx) : 18'h0;
`else
        e.hm = 18'h0;
`endif
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scan(int x0, int x1, int y0, int y1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                xCount = 10'(x);
                yCount = 10'(y);
                tick();
            end
        end
    endtask

    task automatic run_frame(int fx, int fy, bit push, bit ack_pub, bit chk_lat, string tag);
        px = 10'(fx);
        py = 10'(fy);
        if (push) sbq.push_back(model(fx, fy));
        xCount = 10'd0;
        yCount = 10'd481;
        tick();
        tick();
        yCount = 10'd0;
        tick();
        scan(imax(fx - 8, 0), imin(fx + 27, 639), imax(fy - 8, 0), imin(fy + 27, 479));
        xCount = 10'd0;
        yCount = 10'd480;
        tick();
        if (chk_lat) chk({tag, "_lat"}, 32'(res_valid), 32'd0);
        if (ack_pub) res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
    endtask

    task automatic check_res(string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_valid"}, 32'(res_valid), 32'd1);
            chk({tag, "_blocked"}, 32'(blocked), 32'(e.blk));
            chk({tag, "_overlap"}, 32'(overlap), 32'(e.ovl));
            chk({tag, "_hitmask"}, 32'(hit_mask), 32'(e.hm));
        end
    endtask

    task automatic do_ack(string tag);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        chk({tag, "_valid"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; res_ack = 1'b0;
        xCount = '0; yCount = '0; px = '0; py = '0;
        wall_en = 1'b0; wx0 = 0; wx1 = 0; wy0 = 0; wy1 = 0; widx = 0;
        repeat (3) tick();
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_blocked", 32'(blocked), 32'd0);
        chk("rst_overlap", 32'(overlap), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_hitmask", 32'(hit_mask), 32'd0);
        rst = 1'b0;
        tick();

        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        chk("idle_ack_valid", 32'(res_valid), 32'd0);
        chk("idle_ack_overrun", 32'(overrun), 32'd0);

        // Reset in the middle of a frame that would report an overlap
        wall_en = 1'b1; wx0 = 205; wx1 = 205; wy0 = 205; wy1 = 205; widx = 1;
        px = 10'd200; py = 10'd200;
        xCount = 10'd0; yCount = 10'd481; tick(); tick();
        yCount = 10'd0; tick();
        scan(192, 227, 192, 205);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        scan(192, 227, 206, 227);
        xCount = 10'd0; yCount = 10'd480;
        repeat (3) tick();
        chk("midrst_valid", 32'(res_valid), 32'd0);

        wall_en = 1'b0;
        run_frame(200, 200, 1'b1, 1'b0, 1'b1, "clean");
        check_res("clean");
        do_ack("clean_ack");
        chk("clean_overrun", 32'(overrun), 32'd0);

        wall_en = 1'b1; wx0 = 210; wx1 = 230; wy0 = 192; wy1 = 197; widx = 0;
        run_frame(200, 200, 1'b1, 1'b0, 1'b1, "up");
        chk("up_const", 32'(blocked), 32'b1000);
        check_res("up");
        do_ack("up_ack");

        wall_en = 1'b0;
        run_frame(2, 100, 1'b1, 1'b0, 1'b1, "lclamp");
        chk("lclamp_const", 32'(blocked), 32'b0010);
        check_res("lclamp");
        do_ack("lclamp_ack");
        run_frame(620, 100, 1'b1, 1'b0, 1'b1, "r620");
        chk("r620_const", 32'(blocked), 32'b0000);
        check_res("r620");
        do_ack("r620_ack");
        run_frame(621, 100, 1'b1, 1'b0, 1'b1, "r621");
        chk("r621_const", 32'(blocked), 32'b0001);
        check_res("r621");
        do_ack("r621_ack");

        wall_en = 1'b1; wx0 = 205; wx1 = 205; wy0 = 205; wy1 = 205; widx = 3;
        run_frame(200, 200, 1'b1, 1'b0, 1'b1, "ovl");
        chk("ovl_const", 32'(overlap), 32'd1);
`ifdef COLLIDE_HITMASK_EN
        chk("ovl_hm_const", 32'(hit_mask), 32'h00008);
`endif
        check_res("ovl");
        do_ack("ovl_ack");

        // Ack on the publish cycle of a new result: no overrun
        wall_en = 1'b0;
        run_frame(300, 300, 1'b1, 1'b0, 1'b1, "pubA");
        check_res("pubA");
        wall_en = 1'b1; wx0 = 305; wx1 = 305; wy0 = 305; wy1 = 305; widx = 5;
        run_frame(300, 300, 1'b1, 1'b1, 1'b0, "pubB");
        check_res("pubB");
        chk("pubB_overrun", 32'(overrun), 32'd0);
        do_ack("pubB_ack");

        // Two publishes without ack: second result shown, overrun sticky
        wx0 = 105; wx1 = 105; wy0 = 105; wy1 = 105; widx = 2;
        run_frame(100, 100, 1'b0, 1'b0, 1'b1, "ovrC");
        wall_en = 1'b0;
        run_frame(100, 100, 1'b1, 1'b0, 1'b0, "ovrD");
        check_res("ovrD");
        chk("ovrD_overrun", 32'(overrun), 32'd1);
        do_ack("ovrD_ack");
        chk("ovrD_overrun_kept", 32'(overrun), 32'd1);
        tick();
        chk("ovrD_valid_held0", 32'(res_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
